// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  mthi,
    input  logic                  mtlo,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            is_div_q, neg_res_q, neg_rem_q, div_zero_q;
    logic [W-1:0]    raw_a_q, a_mag_q, b_mag_q;
    logic [2*W-1:0]  acc_q;

    // Issue-time operand conditioning: op[0]=1 selects the unsigned variants.
    logic            signed_op, a_neg, b_neg;
    logic [W-1:0]    a_mag_in, b_mag_in;

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & rs_data[W-1];
    assign b_neg     = signed_op & rt_data[W-1];
    assign a_mag_in  = a_neg ? -rs_data : rs_data;
    assign b_mag_in  = b_neg ? -rt_data : rt_data;

    // Iteration step and final sign fix-up.
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next, div_next, mul_res;
    logic [W:0]      rem_sh;
    logic [W-1:0]    div_diff, quot, rem, quot_fix, rem_fix;
    logic            div_ge;
    logic [W-1:0]    fix_hi, fix_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(W - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_mag_q} : {(W+1){1'b0}});
        mul_next = {mul_sum, acc_q[W-1:1]};

        // Restoring divide: remainder in the upper half, dividend shifts out of
        // the lower half while quotient bits shift in behind it.
        rem_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
        div_ge   = rem_sh >= {1'b0, b_mag_q};
        div_diff = rem_sh[W-1:0] - b_mag_q;
        div_next = div_ge ? {div_diff, acc_q[W-2:0], 1'b1}
                          : {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};

        mul_res  = neg_res_q ? -acc_q : acc_q;
        quot     = acc_q[W-1:0];
        rem      = acc_q[2*W-1:W];
        quot_fix = neg_res_q ? -quot : quot;
        rem_fix  = neg_rem_q ? -rem : rem;

        fix_hi = mul_res[2*W-1:W];
        fix_lo = mul_res[W-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                fix_hi = raw_a_q;
                fix_lo = {W{1'b1}};
            end else begin
                fix_hi = rem_fix;
                fix_lo = quot_fix;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            raw_a_q    <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            acc_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        is_div_q   <= op[1];
                        neg_res_q  <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        div_zero_q <= (rt_data == '0);
                        raw_a_q    <= rs_data;
                        a_mag_q    <= a_mag_in;
                        b_mag_q    <= b_mag_in;
                        acc_q      <= {{W{1'b0}}, (op[1] ? a_mag_in : b_mag_in)};
                        cnt_q      <= '0;
                        busy       <= 1'b1;
                    end else begin
                        if (mthi) hi <= rs_data;
                        if (mtlo) lo <= rs_data;
                    end
                end
                S_RUN: begin
                    acc_q <= is_div_q ? div_next : mul_next;
                    cnt_q <= cnt_q + CW'(1);
                end
                S_FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        mthi, mtlo;
    logic        busy, done;
    logic [31:0] hi, lo;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data), .mthi(mthi), .mtlo(mtlo),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    typedef struct {
        string       name;
        logic [31:0] h;
        logic [31:0] l;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got hi=%h lo=%h required no pulse", hi, lo);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_hi"}, hi, e.h);
                check({e.name, "_lo"}, lo, e.l);
            end
        end
        if (done && done_prev) begin
            tests++;
            fails++;
            $display("FAIL done_width: got 2+ cycles required 1");
        end
        done_prev <= done;
    end

    // Issue one operation, count busy cycles and confirm HI/LO hold until done.
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input bit with_mthi, input bit disturb);
        logic [31:0] prev_hi, prev_lo;
        int          cnt;
        bit          hold_ok;
        exp_t        e;
        e.name = name; e.h = eh; e.l = el;
        exp_q.push_back(e);
        prev_hi = hi;
        prev_lo = lo;
        op = o; rs_data = a; rt_data = b; start = 1'b1; mthi = with_mthi;
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        cnt = 0;
        hold_ok = 1'b1;
        forever begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            if (hi !== prev_hi || lo !== prev_lo) hold_ok = 1'b0;
            if (disturb && cnt == 5) begin
                start = 1'b1; mthi = 1'b1; mtlo = 1'b1;
                op = OP_MULTU; rs_data = 32'h0000_1234; rt_data = 32'h0000_5678;
            end else if (disturb && cnt == 6) begin
                start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
            end
            if (cnt > 100) begin
                $display("FAIL %s_timeout: got busy > 100 cycles required 33", name);
                break;
            end
        end
        check({name, "_busy_cycles"}, 32'(cnt), 32'd33);
        check({name, "_hold"}, {31'd0, hold_ok}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0; mthi = 1'b0; mtlo = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
        run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0);
        run_op("mult_neg2xneg3", OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd0, 32'd6, 0, 0);
        run_op("multu_2p31x2", OP_MULTU, 32'h8000_0000, 32'd2, 32'd1, 32'd0, 0, 0);
        run_op("div_neg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0);
        run_op("div_7byneg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 0);
        run_op("divu_7by2", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 0, 0);
        run_op("divu_7by0", OP_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 0, 0);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 0, 0);

        // Register moves in IDLE.
        rs_data = 32'h1234_5678; mthi = 1'b1;
        @(posedge clk); #1 mthi = 1'b0;
        @(negedge clk);
        check("mthi_hi", hi, 32'h1234_5678);
        rs_data = 32'hCAFE_F00D; mtlo = 1'b1;
        @(posedge clk); #1 mtlo = 1'b0;
        @(negedge clk);
        check("mtlo_lo", lo, 32'hCAFE_F00D);
        check("mtlo_hi_kept", hi, 32'h1234_5678);

        run_op("start_with_mthi", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1, 0);
        run_op("busy_disturb", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 0, 1);

        // Abort a divide with reset ten cycles in.
        op = OP_DIV; rs_data = 32'hFFFF_FFF9; rt_data = 32'd2; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);

        run_op("div_neg100by7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 0, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Iterative multiply/divide execution unit owning the HI/LO register pair. Sits directly downstream of the register file: consumes the two register read ports (rs/rt operands) when the decoder issues MULT/MULTU/DIV/DIVU. Produces the HI/LO results read back by MFHI/MFLO. Asserts busy so the pipeline control stalls HI/LO readers and new mult/div issues until results land.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; iteration count equals DATA_WIDTH; counter width is $clog2(DATA_WIDTH).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset; one clock, sampled on rising edge of clk
start  input  1  issue request, sampled only in IDLE
op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_data  input  DATA_WIDTH  operand A (multiplicand / dividend), from register file read_data1
rt_data  input  DATA_WIDTH  operand B (multiplier / divisor), from register file read_data2
mthi  input  1  write rs_data into HI
mtlo  input  1  write rs_data into LO
busy  output  1  operation in flight
done  output  1  one-cycle pulse when HI/LO updated by an operation
hi  output  DATA_WIDTH  HI register
lo  output  DATA_WIDTH  LO register

Behaviour:
- Reset (synchronous, high): state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0, internal datapath regs=0. Reset mid-operation aborts it; no HI/LO update, outputs 0 the cycle after the reset edge.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at edge N: latch op, operand magnitudes (abs for MULT/DIV, raw for unsigned) and result signs; counter<=0; busy<=1; state<=RUN. mthi/mtlo ignored on that edge (start has priority).
- IDLE, start=0: mthi=1 -> hi<=rs_data; mtlo=1 -> lo<=rs_data; both may assert together.
- RUN: one iteration per edge (edges N+1..N+32). Multiply: shift-add into 2*DATA_WIDTH unsigned product. Divide: restoring divide, one quotient bit per edge, remainder/quotient unsigned. counter increments; at counter==DATA_WIDTH-1, state<=FIX.
- FIX (edge N+33): apply sign correction, write hi/lo, done<=1 for exactly one cycle, busy<=0, state<=IDLE. New start accepted in the cycle after (sampled at edge N+34 earliest).
- busy is high for exactly 33 cycles per operation; HI/LO hold prior values until edge N+33.
- start, mthi, mtlo while busy: ignored, no effect on operation or HI/LO.
- op/rs_data/rt_data may change freely after edge N; only the values latched at N are used.
- Multiply results: {hi,lo} = full 64-bit product; MULT = two's-complement signed product (negate magnitude product if sign(A) xor sign(B)); MULTU unsigned.
- Divide results: lo=quotient, hi=remainder. DIV: quotient negated if signs differ; remainder takes sign of dividend (truncation toward zero). DIVU unsigned.
- Signed overflow DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero (DIV or DIVU, rt_data=0): lo=0xFFFFFFFF, hi=rs_data (original, unsigned-raw value); full 33-cycle latency still taken, done still pulses.
- No combinational path from inputs to outputs; busy, done, hi, lo are registers.

Test Plan:
- Reset, MULTU 0xFFFFFFFF*0xFFFFFFFF start at edge N -> busy 1 for 33 cycles, done pulse at N+33, hi=0xFFFFFFFE, lo=0x00000001; hi/lo remain 0 before N+33.
- MULT rs=0xFFFFFFFD (-3), rt=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1.
- Boundaries: DIVU 7/0 -> hi=7, lo=0xFFFFFFFF after 33 cycles; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- IDLE mthi rs=0x12345678 then mtlo rs=0xCAFEF00D -> hi/lo updated next edge; same-edge start+mthi -> mthi dropped, only operation result lands.
- During busy: pulse start (op MULTU, new operands), mthi, mtlo, and change rs/rt -> ignored; result matches original operands, busy still exactly 33 cycles.
- Assert reset 10 cycles into a DIV -> next cycle busy=0, done=0, hi=lo=0; following start completes normally with correct result.
